// File: rtl/mem_pkg.sv
// Shared encodings for the memory access controller: FSM states, store/load
// size codes, the default ack timeout and the alignment helpers.
package mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } size_e;

  localparam logic [1:0] ST_SW = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SB = 2'b10;

  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LBU = 3'b001;
  localparam logic [2:0] LD_LB  = 3'b010;
  localparam logic [2:0] LD_LHU = 3'b011;
  localparam logic [2:0] LD_LH  = 3'b100;

  localparam int TIMEOUT_DEFAULT = 255;

  // Unknown store/load codes fall back to a full word access.
  function automatic size_e accessSize(input logic       isStore,
                                       input logic [1:0] stType,
                                       input logic [2:0] ldType);
    size_e sz;
    sz = SZ_WORD;
    if (isStore) begin
      case (stType)
        ST_SH:   sz = SZ_HALF;
        ST_SB:   sz = SZ_BYTE;
        default: sz = SZ_WORD;
      endcase
    end else begin
      case (ldType)
        LD_LBU, LD_LB: sz = SZ_BYTE;
        LD_LHU, LD_LH: sz = SZ_HALF;
        default:       sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

  function automatic logic isAligned(input size_e sz, input logic [1:0] addrLow);
    logic ok;
    case (sz)
      SZ_WORD: ok = (addrLow == 2'b00);
      SZ_HALF: ok = ~addrLow[0];
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_be_gen.sv
// Byte-enable and write-lane generator: replicates sub-word store data across
// all lanes so the memory only needs the byte enables to pick the target lane.
module be_gen
  import mem_pkg::*;
(
  input  logic [1:0]  st_type_i,
  input  logic        req_we_i,
  input  logic [1:0]  addr_low_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o
);

  always_comb begin
    mem_be_o    = 4'b0000;
    mem_wdata_o = 32'h0000_0000;
    if (req_we_i) begin
      case (st_type_i)
        ST_SH: begin
          mem_be_o    = addr_low_i[1] ? 4'b1100 : 4'b0011;
          mem_wdata_o = {2{wdata_i[15:0]}};
        end
        ST_SB: begin
          mem_be_o    = 4'b0001 << addr_low_i;
          mem_wdata_o = {4{wdata_i[7:0]}};
        end
        default: begin
          mem_be_o    = 4'b1111;
          mem_wdata_o = wdata_i;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// M-stage memory access controller: checks alignment, issues one bus request
// per aligned access, waits for ack with a timeout and hands load data onward.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  st_type,
  input  logic [2:0]  ld_type,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        bus_err,
  output logic        rd_valid,
  output logic [31:0] rd_word,
  output logic [1:0]  rd_addrlow,
  output logic [2:0]  rd_ldsel
);

  localparam int CNT_W = $clog2(TIMEOUT + 2);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   waitCnt_q, waitCnt_d;
  logic               busErr_q, busErr_d;
  logic               reqWe_q;
  logic [31:0]        reqAddr_q;
  logic [31:0]        reqWdata_q;
  logic [1:0]         reqStType_q;
  logic [2:0]         reqLdType_q;
  logic [31:0]        rdWord_q;
  logic [1:0]         rdAddrLow_q;
  logic [2:0]         rdLdSel_q;

  logic               aligned;
  logic               accept;
  logic               timeoutHit;
  logic               ackInReq;
  logic [3:0]         genBe;
  logic [31:0]        genWdata;

  assign aligned    = isAligned(accessSize(req_we, st_type, ld_type), addr[1:0]);
  assign accept     = req_valid & aligned;
  assign ackInReq   = (state_q == S_REQ) & mem_ack;
  // The cycle that would bring the count to TIMEOUT is the last REQ cycle.
  assign timeoutHit = (int'(waitCnt_q) + 1) >= TIMEOUT;

  be_gen u_be_gen (
    .st_type_i   (reqStType_q),
    .req_we_i    (reqWe_q),
    .addr_low_i  (reqAddr_q[1:0]),
    .wdata_i     (reqWdata_q),
    .mem_be_o    (genBe),
    .mem_wdata_o (genWdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      waitCnt_q <= '0;
      busErr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      busErr_q  <= busErr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_REQ;
      S_REQ:   if (mem_ack || timeoutHit) state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    waitCnt_d = waitCnt_q;
    busErr_d  = 1'b0;
    case (state_q)
      S_IDLE: if (accept) waitCnt_d = '0;
      S_REQ: begin
        if (!mem_ack) begin
          waitCnt_d = waitCnt_q + CNT_W'(1);
          busErr_d  = timeoutHit;
        end
      end
      default: ;
    endcase
  end

  // Request capture keeps the bus stable even if the pipeline inputs move.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reqWe_q     <= 1'b0;
      reqAddr_q   <= '0;
      reqWdata_q  <= '0;
      reqStType_q <= '0;
      reqLdType_q <= '0;
    end else if ((state_q == S_IDLE) && accept) begin
      reqWe_q     <= req_we;
      reqAddr_q   <= addr;
      reqWdata_q  <= wdata;
      reqStType_q <= st_type;
      reqLdType_q <= ld_type;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdWord_q    <= '0;
      rdAddrLow_q <= '0;
      rdLdSel_q   <= '0;
    end else if (ackInReq && !reqWe_q) begin
      rdWord_q    <= mem_rdata;
      rdAddrLow_q <= reqAddr_q[1:0];
      rdLdSel_q   <= reqLdType_q;
    end
  end

  // Reset also gates the combinational outputs so nothing leaks while it is held.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0000_0000;
    mem_be    = 4'b0000;
    mem_wdata = 32'h0000_0000;
    stall     = 1'b0;
    exc_adel  = 1'b0;
    exc_ades  = 1'b0;
    rd_valid  = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IDLE: begin
          stall    = accept;
          exc_adel = req_valid & ~aligned & ~req_we;
          exc_ades = req_valid & ~aligned & req_we;
        end
        S_REQ: begin
          mem_req   = 1'b1;
          mem_we    = reqWe_q;
          mem_addr  = {reqAddr_q[31:2], 2'b00};
          mem_be    = genBe;
          mem_wdata = genWdata;
          stall     = 1'b1;
        end
        S_RESP: rd_valid = ~reqWe_q & ~busErr_q;
        default: ;
      endcase
    end
  end

  assign bus_err    = busErr_q;
  assign rd_word    = rdWord_q;
  assign rd_addrlow = rdAddrLow_q;
  assign rd_ldsel   = rdLdSel_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed plus randomized bench for mem_access_ctrl; expectations come from a
// byte-count/lane model of each access rather than from the controller's FSM.
module tb_mem_access_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  st_type;
  logic [2:0]  ld_type;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        exc_adel;
  logic        exc_ades;
  logic        bus_err;
  logic        rd_valid;
  logic [31:0] rd_word;
  logic [1:0]  rd_addrlow;
  logic [2:0]  rd_ldsel;

  int checks = 0;
  int errors = 0;

  logic [31:0] expRdWord;
  logic [1:0]  expRdAddrLow;
  logic [2:0]  expRdLdSel;

  mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .addr       (addr),
    .wdata      (wdata),
    .st_type    (st_type),
    .ld_type    (ld_type),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .stall      (stall),
    .exc_adel   (exc_adel),
    .exc_ades   (exc_ades),
    .bus_err    (bus_err),
    .rd_valid   (rd_valid),
    .rd_word    (rd_word),
    .rd_addrlow (rd_addrlow),
    .rd_ldsel   (rd_ldsel)
  );

  always #5 clk = ~clk;

  function automatic int sizeBytes(input logic we, input logic [1:0] st, input logic [2:0] ld);
    int n;
    if (we) n = (st == 2'b01) ? 2 : (st == 2'b10) ? 1 : 4;
    else if (ld == 3'd1 || ld == 3'd2) n = 1;
    else if (ld == 3'd3 || ld == 3'd4) n = 2;
    else n = 4;
    return n;
  endfunction

  function automatic logic [3:0] modelBe(input logic we, input int n, input logic [31:0] a);
    int lanes;
    lanes = ((1 << n) - 1) << int'(a[1:0]);
    return we ? 4'(lanes) : 4'b0000;
  endfunction

  function automatic logic [31:0] modelWdata(input int n, input logic [31:0] w);
    logic [31:0] r;
    if (n == 1) r = 32'(w[7:0]) * 32'h0101_0101;
    else if (n == 2) r = 32'(w[15:0]) * 32'h0001_0001;
    else r = w;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic we, input logic [1:0] st,
                               input logic [2:0] ld, input logic [31:0] a, input logic [31:0] w);
    req_valid = v;
    req_we    = we;
    st_type   = st;
    ld_type   = ld;
    addr      = a;
    wdata     = w;
  endtask

  task automatic checkQuietIdle(input string name);
    checkOutput({name, ".idle_req"}, 32'(mem_req), 32'd0);
    checkOutput({name, ".idle_stall"}, 32'(stall), 32'd0);
    checkOutput({name, ".idle_rdvalid"}, 32'(rd_valid), 32'd0);
    checkOutput({name, ".idle_buserr"}, 32'(bus_err), 32'd0);
  endtask

  // Starts and ends just after a rising edge. ackDelay = index of the REQ
  // cycle carrying mem_ack; values >= TO mean the ack never comes in time.
  task automatic doTransaction(input string name, input logic we, input logic [1:0] st,
                               input logic [2:0] ld, input logic [31:0] a, input logic [31:0] w,
                               input int ackDelay, input logic [31:0] rdata);
    int  n;
    bit  okAlign;
    bit  acked;
    int  reqCycles;
    int  stallCnt;
    n       = sizeBytes(we, st, ld);
    okAlign = (int'(a[1:0]) % n) == 0;
    applyStimulus(1'b1, we, st, ld, a, w);
    @(negedge clk);
    checkOutput({name, ".accept_stall"}, 32'(stall), 32'(okAlign));
    checkOutput({name, ".exc_adel"}, 32'(exc_adel), 32'(!okAlign && !we));
    checkOutput({name, ".exc_ades"}, 32'(exc_ades), 32'(!okAlign && we));
    checkOutput({name, ".accept_req"}, 32'(mem_req), 32'd0);
    if (!okAlign) begin
      @(posedge clk); #1;
      applyStimulus(1'b0, 1'b0, 2'b00, 3'd0, 32'h0, 32'h0);
      @(negedge clk);
      checkQuietIdle({name, ".stay"});
      @(posedge clk); #1;
      return;
    end
    stallCnt  = 1;
    acked     = ackDelay < TO;
    reqCycles = acked ? ackDelay + 1 : TO;
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)), $urandom, $urandom);
    for (int k = 0; k < reqCycles; k++) begin
      mem_ack   = acked && (k == ackDelay);
      mem_rdata = mem_ack ? rdata : $urandom;
      @(negedge clk);
      checkOutput({name, ".req"}, 32'(mem_req), 32'd1);
      checkOutput({name, ".we"}, 32'(mem_we), 32'(we));
      checkOutput({name, ".addr"}, mem_addr, a & ~32'h3);
      checkOutput({name, ".be"}, 32'(mem_be), 32'(modelBe(we, n, a)));
      if (we) checkOutput({name, ".wdata"}, mem_wdata, modelWdata(n, w));
      checkOutput({name, ".req_rdvalid"}, 32'(rd_valid), 32'd0);
      if (stall) stallCnt++;
      @(posedge clk); #1;
    end
    if (acked && !we) begin
      expRdWord    = rdata;
      expRdAddrLow = a[1:0];
      expRdLdSel   = ld;
    end
    // Ack and a fresh request during RESP must both be ignored.
    mem_ack = 1'b1;
    applyStimulus(1'b1, 1'b0, 2'b00, 3'd0, 32'h0000_0100, 32'h0);
    @(negedge clk);
    checkOutput({name, ".resp_req"}, 32'(mem_req), 32'd0);
    checkOutput({name, ".resp_stall"}, 32'(stall), 32'd0);
    checkOutput({name, ".resp_rdvalid"}, 32'(rd_valid), 32'(acked && !we));
    checkOutput({name, ".resp_buserr"}, 32'(bus_err), 32'(!acked));
    checkOutput({name, ".rd_word"}, rd_word, expRdWord);
    checkOutput({name, ".rd_addrlow"}, 32'(rd_addrlow), 32'(expRdAddrLow));
    checkOutput({name, ".rd_ldsel"}, 32'(rd_ldsel), 32'(expRdLdSel));
    checkOutput({name, ".stall_cycles"}, 32'(stallCnt), 32'(reqCycles + 1));
    @(posedge clk); #1;
    mem_ack = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'b00, 3'd0, 32'h0, 32'h0);
    @(negedge clk);
    checkQuietIdle({name, ".after"});
    @(posedge clk); #1;
  endtask

  initial begin
    reset     = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    applyStimulus(1'b0, 1'b0, 2'b00, 3'd0, 32'h0, 32'h0);
    expRdWord    = 32'h0;
    expRdAddrLow = 2'b00;
    expRdLdSel   = 3'd0;
    #2;
    checkQuietIdle("reset");
    checkOutput("reset.rd_word", rd_word, 32'h0);
    checkOutput("reset.rd_ldsel", 32'(rd_ldsel), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    doTransaction("sb_1003", 1'b1, 2'b10, 3'd0, 32'h0000_1003, 32'h0000_00AB, 0, 32'h0);
    doTransaction("lh_2002", 1'b0, 2'b00, 3'b100, 32'h0000_2002, 32'h0, 3, 32'h8001_1234);
    doTransaction("lw_mis", 1'b0, 2'b00, 3'b000, 32'h0000_0006, 32'h0, 0, 32'h0);
    doTransaction("sh_mis", 1'b1, 2'b01, 3'd0, 32'h0000_0001, 32'h1234, 0, 32'h0);
    doTransaction("lw_timeout", 1'b0, 2'b00, 3'b000, 32'h0000_0040, 32'h0, 99, 32'hFFFF_FFFF);
    doTransaction("sh_hi", 1'b1, 2'b01, 3'd0, 32'h0000_0A02, 32'hCAFE_5678, 1, 32'h0);
    doTransaction("sw_11", 1'b1, 2'b11, 3'd0, 32'h0000_0B04, 32'h1357_9BDF, 2, 32'h0);

    // Stray ack while idle must not start anything.
    mem_ack = 1'b1;
    @(negedge clk);
    checkOutput("idle_ack.req", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    checkQuietIdle("idle_ack");
    @(posedge clk); #1;

    // Reset during the second REQ cycle drops the access immediately.
    applyStimulus(1'b1, 1'b1, 2'b00, 3'd0, 32'h0000_3000, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 2'b00, 3'd0, 32'h0, 32'h0);
    @(posedge clk); #1;
    checkOutput("rst_mid.req_before", 32'(mem_req), 32'd1);
    reset = 1'b1;
    #1;
    expRdWord    = 32'h0;
    expRdAddrLow = 2'b00;
    expRdLdSel   = 3'd0;
    checkQuietIdle("rst_mid");
    checkOutput("rst_mid.rd_word", rd_word, 32'h0);
    checkOutput("rst_mid.rd_addrlow", 32'(rd_addrlow), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    doTransaction("sw_after_rst", 1'b1, 2'b00, 3'd0, 32'h0000_3004, 32'h0BAD_F00D, 1, 32'h0);

    for (int i = 0; i < 40; i++) begin
      doTransaction($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    3'($urandom_range(0, 4)), $urandom, $urandom, int'($urandom_range(0, 5)),
                    $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
